tdm_burst_framer: RTL and testbench
===================================

Name: tdm_burst_framer

Overview:
Downstream stage after the TDM multiply/post-processing output, in the clk100m domain. Buffers the 16-bit result stream in a small FIFO. Emits fixed-length framed bursts on a valid/ready interface: a header word carrying a sequence number, then BURST_LEN payload words, then a checksum trailer word. The upstream path has no backpressure, so words arriving while the FIFO is full are dropped and flagged.

Parameters:
DATA_WIDTH, 16, width of the data and output words (must be 16)
BURST_LEN, 8, payload words per burst (2..FIFO_DEPTH)
FIFO_DEPTH, 16, input FIFO entries (power of 2, at least BURST_LEN)
HDR_TAG, 8'hA5, upper byte of the header word

Ports:
clk  in  1  system clock (clk100m)
rst  in  1  reset; asynchronous, active-high
din  in  DATA_WIDTH  result word from post-processing
din_valid  in  1  din is valid this cycle
din_ready  out  1  FIFO not full (informational; upstream does not stall)
dout  out  DATA_WIDTH  framed output word
dout_valid  out  1  dout is valid
dout_ready  in  1  sink accepts dout
dout_sop  out  1  high with the header word
dout_eop  out  1  high with the trailer word
overflow  out  1  sticky; a word was dropped
seq_num  out  8  sequence number of the next burst to be sent

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE; dout=0, dout_valid=0, dout_sop=0, dout_eop=0, overflow=0, seq_num=0, checksum=0, din_ready=1.
- Reset asserted mid-burst aborts the burst; no partial burst resumes after release.
- Write: push on din_valid && !full.
- din_valid && full: word dropped, overflow<=1, stays set until reset.
- din_ready = !full, from registered count. A same-cycle pop does not admit a write when full.
- Transfer: a word is accepted when dout_valid && dout_ready.
- While dout_valid && !dout_ready: dout, dout_sop and dout_eop hold stable.
- All outputs are registered.
- State IDLE:
  - When fifo_count >= BURST_LEN: load header {HDR_TAG, seq_num}, dout_sop=1, dout_valid=1, clear checksum, go to HDR.
  - The header appears one cycle after the BURST_LEN-th word is written, so a started burst never stalls on empty.
- State HDR:
  - On transfer: pop FIFO head to dout, checksum <= head, go to PAY with payload index = 1.
- State PAY:
  - On transfer with index < BURST_LEN: pop next word, checksum += word (mod 2^16), index++.
  - On transfer with index == BURST_LEN: dout = checksum, dout_eop=1, go to TRL.
- State TRL:
  - On transfer: seq_num++ (wraps 255->0).
  - If fifo_count >= BURST_LEN (count as of that cycle): load the next header immediately, back-to-back with no idle cycle, go to HDR.
  - Otherwise: dout_valid=0, go to IDLE.
- Simultaneous push and pop: both occur; count unchanged.
- Checksum is the sum of payload words only, truncated to 16 bits. Header and trailer are excluded.
- With dout_ready held high, a burst occupies BURST_LEN+2 consecutive cycles.

Decomposition:
- Package tdm_burst_pkg holds:
  - state enum {IDLE, HDR, PAY, TRL}
  - default HDR_TAG constant
  - header-build function (tag, seq) -> 16-bit word
- Sub-module burst_sync_fifo: single-clock FIFO with async reset and registered count/full/empty outputs. Parameters are DATA_WIDTH and FIFO_DEPTH.
- The framer FSM, checksum and sequence counter stay in tdm_burst_framer.

Test Plan:
- Basic burst: write 16'h0001..16'h0008 on consecutive cycles, dout_ready=1.
  - Header 16'hA500 with sop, one cycle after the 8th write.
  - Then payload 1..8, then trailer 16'h0024 with eop.
  - Then seq_num=1, dout_valid=0.
- Partial burst: write only 7 words -> dout_valid stays 0. The 8th write then triggers a burst.
- Backpressure: during payload, toggle dout_ready 1/0 randomly.
  - dout, sop and eop hold while stalled.
  - Sequence is exactly header, 1..8, trailer with no loss or duplication.
  - Checksum is still 16'h0024.
- Overflow: dout_ready=0, write 17 words 16'h0100..16'h0110.
  - din_ready falls after the 16th write; 17th word dropped, overflow=1.
  - Release dout_ready -> two bursts with payloads 0x0100..0x0107 and 0x0108..0x010F.
  - Checksums 16'h081C and 16'h085C; overflow stays 1.
- Back-to-back and wrap:
  - Stream 256 bursts continuously with dout_ready=1 -> no idle cycle between bursts.
  - Headers run 16'hA500..16'hA5FF; the next header is 16'hA500.
  - Checksum of payload 16'hFFFF x8 = 16'hFFF8.
- Reset mid-burst: assert rst on the 4th payload transfer.
  - dout_valid=0, overflow=0 and seq_num=0 immediately, asynchronously.
  - After release, 8 new writes yield header 16'hA500 and a correct fresh burst.

Source files
------------

// File: rtl/tdm_burst_pkg.sv
// Shared types and helpers for the TDM burst framer.
// Holds the framer state encoding and the header word builder.
package tdm_burst_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        TRL
    } state_t;

    localparam logic [7:0] DEF_HDR_TAG = 8'hA5;

    function automatic logic [15:0] build_hdr(
        input logic [7:0] tag,
        input logic [7:0] seq
    );
        return {tag, seq};
    endfunction

endpackage

// File: rtl/burst_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head.
// Count, full and empty are registered.
module burst_sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               wr_en,
    input  logic                               rd_en,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               full,
    output logic                               empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count_nxt;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(FIFO_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/tdm_burst_framer.sv
// Frames the post-processed TDM result stream into header/payload/trailer
// bursts; words arriving while the FIFO is full are dropped and flagged.
module tdm_burst_framer
    import tdm_burst_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         BURST_LEN  = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HDR_TAG    = DEF_HDR_TAG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sop,
    output logic                  dout_eop,
    output logic                  overflow,
    output logic [7:0]            seq_num
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int IW = $clog2(BURST_LEN+1);

    state_t                state;
    logic [DATA_WIDTH-1:0] head;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] csum;
    logic                  xfer;
    logic                  burst_rdy;
    logic                  pop;

    assign xfer      = dout_valid && dout_ready;
    assign burst_rdy = (fifo_count >= CW'(BURST_LEN));
    assign din_ready = !fifo_full;
    // Header and the first BURST_LEN-1 payload transfers each pull the next word.
    assign pop = xfer && !fifo_empty &&
                 ((state == HDR) || ((state == PAY) && (idx < IW'(BURST_LEN))));

    burst_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_data(din),
        .wr_en  (din_valid),
        .rd_en  (pop),
        .rd_data(head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (din_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            seq_num    <= '0;
            csum       <= '0;
            idx        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (burst_rdy) begin
                        dout       <= build_hdr(HDR_TAG, seq_num);
                        dout_valid <= 1'b1;
                        dout_sop   <= 1'b1;
                        csum       <= '0;
                        state      <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        dout     <= head;
                        dout_sop <= 1'b0;
                        csum     <= head;
                        idx      <= IW'(1);
                        state    <= PAY;
                    end
                end
                PAY: begin
                    if (xfer) begin
                        if (idx < IW'(BURST_LEN)) begin
                            dout <= head;
                            csum <= csum + head;
                            idx  <= idx + 1'b1;
                        end else begin
                            dout     <= csum;
                            dout_eop <= 1'b1;
                            state    <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (xfer) begin
                        seq_num  <= seq_num + 8'd1;
                        dout_eop <= 1'b0;
                        if (burst_rdy) begin
                            dout     <= build_hdr(HDR_TAG, seq_num + 8'd1);
                            dout_sop <= 1'b1;
                            csum     <= '0;
                            state    <= HDR;
                        end else begin
                            dout_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_burst_framer.sv
// Randomised bench for tdm_burst_framer against a word-stream reference
// model: every 8 accepted words become header, payload, checksum.
module tb_tdm_burst_framer;

    localparam int BL    = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_sop;
    logic        dout_eop;
    logic        overflow;
    logic [7:0]  seq_num;

    always #5 clk = ~clk;

    tdm_burst_framer #(
        .DATA_WIDTH(16),
        .BURST_LEN (BL),
        .FIFO_DEPTH(DEPTH),
        .HDR_TAG   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .overflow  (overflow),
        .seq_num   (seq_num)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] acc_q[$];
    logic [17:0] exp_q[$];
    int          occ;
    int          pos;
    int          sent;
    logic [7:0]  seq_m;
    logic        ovf_m;
    logic        exp_vld;
    logic        prev_stall;
    logic [18:0] prev_snap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        acc_q.delete();
        exp_q.delete();
        occ        = 0;
        pos        = 0;
        sent       = 0;
        seq_m      = '0;
        ovf_m      = 1'b0;
        exp_vld    = 1'b0;
        prev_stall = 1'b0;
        prev_snap  = '0;
    endtask

    task automatic build_burst();
        logic [15:0] cs;
        cs = '0;
        exp_q.push_back({2'b10, 8'hA5, seq_m});
        foreach (acc_q[i]) begin
            exp_q.push_back({2'b00, acc_q[i]});
            cs = cs + acc_q[i];
        end
        exp_q.push_back({2'b01, cs});
        seq_m = seq_m + 8'd1;
        acc_q.delete();
    endtask

    // One clock: drive at negedge, check the settled outputs, advance the model.
    task automatic step(input logic v, input logic [15:0] d, input logic r);
        logic [18:0] snap;
        logic        acc;
        logic        fresh;
        @(negedge clk);
        din_valid  = v;
        din        = d;
        dout_ready = r;
        #1;
        snap = {dout_valid, dout_sop, dout_eop, dout};
        check("valid", 32'(dout_valid), 32'(exp_vld));
        check("din_ready", 32'(din_ready), 32'(occ < DEPTH));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("seq_num", 32'(seq_num), 32'(sent % 256));
        if (prev_stall) check("hold", 32'(snap), 32'(prev_snap));
        prev_stall = snap[18] && !r;
        prev_snap  = snap;
        acc   = v && (occ < DEPTH);
        fresh = 1'b0;
        if (snap[18] && r) begin
            if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
            else check("word", 32'(snap[17:0]), 32'(exp_q.pop_front()));
            if (pos < BL) occ--;
            if (pos == BL + 1) sent++;
            pos = (pos + 1) % (BL + 2);
        end
        if (v) begin
            if (acc) begin
                acc_q.push_back(d);
                occ++;
                if (acc_q.size() == BL) begin
                    fresh = (exp_q.size() == 0);
                    build_burst();
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
        exp_vld = (exp_q.size() != 0) && !fresh;
        @(posedge clk);
    endtask

    initial begin
        int guard;
        reset_model();
        #12;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_sop_eop", 32'({dout_sop, dout_eop}), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_seq", 32'(seq_num), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= BL; i++) step(1'b1, 16'(i), 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);
        check("basic_seq", 32'(seq_num), 32'd1);

        for (int i = 0; i < BL - 1; i++) step(1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);

        for (int i = 1; i <= BL; i++) step(1'b1, 16'(i), 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0, 1'($urandom % 2));
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 17; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 30; i++) step(1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom % 10 < 7), 16'($urandom), 1'($urandom % 4 != 0));
        for (int i = 0; i < 40; i++) step(1'b0, 16'h0, 1'b1);

        for (int i = 0; i < BL; i++) step(1'b1, 16'($urandom), 1'b1);
        guard = 0;
        while (pos != 4 && guard < 40) begin
            step(1'b0, 16'h0, 1'b1);
            guard++;
        end
        check("reach_pay4", 32'(pos), 32'd4);
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_seq", 32'(seq_num), 32'd0);
        check("arst_din_ready", 32'(din_ready), 32'd1);
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < BL; i++) step(1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);

        for (int b = 0; b < 257; b++)
            for (int i = 0; i < BL + 2; i++)
                step(1'(i < BL), (b == 100) ? 16'hFFFF : 16'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
